// File: rtl/apb_sevenseg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : apb_sevenseg_slave
//  Description : APB completer owning the register bank of a multiplexed,
//                active-low seven-segment display (hex digits, decimal
//                points, enable, refresh prescaler) plus the digit scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_sevenseg_slave #(
  parameter int          DW          = 32,
  parameter int          AW          = 32,
  parameter int          NDIG        = 8,
  parameter int          WAIT_STATES = 0,
  parameter logic [15:0] REFRESH_DIV = 16'd49999
) (
  input  logic            pCLK,
  input  logic            pRESETn,
  input  logic [AW-1:0]   pADDR,
  input  logic            pSELx,
  input  logic            pENABLE,
  input  logic            pWRITE,
  input  logic [DW-1:0]   pWDATA,
  output logic [DW-1:0]   pRDATA,
  output logic            pREADY,
  output logic            pSLVERR,
  output logic [6:0]      o_seg,
  output logic            o_dp,
  output logic [NDIG-1:0] o_an
);

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);
  localparam logic [2:0] LAST_DIG  = 3'(NDIG - 1);

  localparam logic [4:0] OFS_DATA   = 5'h00;
  localparam logic [4:0] OFS_DP     = 5'h04;
  localparam logic [4:0] OFS_CTRL   = 5'h08;
  localparam logic [4:0] OFS_PRESC  = 5'h0C;
  localparam logic [4:0] OFS_STATUS = 5'h10;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_t;

  apb_state_t       state;
  logic [2:0]       wait_cnt;

  logic [DW-1:0]    data_reg;
  logic [NDIG-1:0]  dp_reg;
  logic             en_reg;
  logic [15:0]      presc_reg;

  logic [15:0]      scan_cnt;
  logic [2:0]       idx;

  logic [4:0]       offset;
  logic             access_phase;
  logic             completing;
  logic             addr_err;
  logic             commit;
  logic [DW-1:0]    reg_rdata;
  logic [3:0]       cur_nib;

  // Upper address bits are not decoded; folded here so they are not dangling.
  logic             unused_addr;
  assign unused_addr = ^pADDR[AW-1:5];

  assign offset       = pADDR[4:0];
  assign access_phase = (state == ACCESS) && pSELx && pENABLE;
  assign completing   = access_phase && (wait_cnt == 3'd0);
  assign commit       = completing && pWRITE && !addr_err;

  // Hex nibble to active-low {g,f,e,d,c,b,a} segment pattern.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Flags misaligned, unmapped and read-only-write accesses.
  always_comb begin
    addr_err = 1'b0;
    if (offset[1:0] != 2'b00) begin
      addr_err = 1'b1;
    end else begin
      case (offset)
        OFS_DATA, OFS_DP, OFS_CTRL, OFS_PRESC: addr_err = 1'b0;
        OFS_STATUS:                           addr_err = pWRITE;
        default:                              addr_err = 1'b1;
      endcase
    end
  end

  // Read mux; unimplemented bits of each register read as zero.
  always_comb begin
    reg_rdata = '0;
    case (offset)
      OFS_DATA:   reg_rdata            = data_reg;
      OFS_DP:     reg_rdata[NDIG-1:0]  = dp_reg;
      OFS_CTRL:   reg_rdata[0]         = en_reg;
      OFS_PRESC:  reg_rdata[15:0]      = presc_reg;
      OFS_STATUS: reg_rdata[2:0]       = idx;
      default:    reg_rdata            = '0;
    endcase
  end

  // Bus response is only ever non-zero in the completing cycle.
  always_comb begin
    pREADY  = completing;
    pSLVERR = completing && addr_err;
    pRDATA  = (completing && !addr_err) ? reg_rdata : '0;
  end

  // APB state machine with wait-state counter loaded at SETUP.
  always_ff @(posedge pCLK or negedge pRESETn) begin
    if (!pRESETn) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pSELx && !pENABLE) begin
            state    <= ACCESS;
            wait_cnt <= WAIT_INIT;
          end
        end
        ACCESS: begin
          if (!pSELx) begin
            // Select dropped mid-transfer: abandon without committing.
            state <= IDLE;
          end else if (pENABLE) begin
            if (wait_cnt == 3'd0) begin
              state <= IDLE;
            end else begin
              wait_cnt <= wait_cnt - 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register bank; writes land on the completing edge of an error-free write.
  always_ff @(posedge pCLK or negedge pRESETn) begin
    if (!pRESETn) begin
      data_reg  <= '0;
      dp_reg    <= '0;
      en_reg    <= 1'b0;
      presc_reg <= REFRESH_DIV;
    end else if (commit) begin
      case (offset)
        OFS_DATA:  data_reg  <= pWDATA;
        OFS_DP:    dp_reg    <= pWDATA[NDIG-1:0];
        OFS_CTRL:  en_reg    <= pWDATA[0];
        OFS_PRESC: presc_reg <= pWDATA[15:0];
        default:   ;
      endcase
    end
  end

  // Refresh prescaler and digit index; held at zero while disabled.
  // Using >= lets a PRESC write below the running count wrap immediately.
  always_ff @(posedge pCLK or negedge pRESETn) begin
    if (!pRESETn) begin
      scan_cnt <= 16'd0;
      idx      <= 3'd0;
    end else if (!en_reg) begin
      scan_cnt <= 16'd0;
      idx      <= 3'd0;
    end else if (scan_cnt >= presc_reg) begin
      scan_cnt <= 16'd0;
      idx      <= (idx == LAST_DIG) ? 3'd0 : idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  assign cur_nib = data_reg[{idx, 2'b00} +: 4];

  // Registered display drive, one cycle behind idx/DATA/DP/EN.
  always_ff @(posedge pCLK or negedge pRESETn) begin
    if (!pRESETn) begin
      o_an  <= '1;
      o_seg <= 7'h7F;
      o_dp  <= 1'b1;
    end else if (!en_reg) begin
      o_an  <= '1;
      o_seg <= 7'h7F;
      o_dp  <= 1'b1;
    end else begin
      o_an  <= ~(NDIG'(1) << idx);
      o_seg <= hex7(cur_nib);
      o_dp  <= ~dp_reg[idx];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_sevenseg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_sevenseg_slave
//  Description : Self-checking bench for apb_sevenseg_slave with a
//                behavioural register/scanner model and random APB traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_sevenseg_slave;

  localparam int NDIG = 8;
  localparam int WS   = 2;

  logic            pCLK;
  logic            pRESETn;
  logic [31:0]     pADDR;
  logic            pSELx;
  logic            pENABLE;
  logic            pWRITE;
  logic [31:0]     pWDATA;
  logic [31:0]     pRDATA;
  logic            pREADY;
  logic            pSLVERR;
  logic [6:0]      o_seg;
  logic            o_dp;
  logic [NDIG-1:0] o_an;

  apb_sevenseg_slave #(
    .DW(32), .AW(32), .NDIG(NDIG), .WAIT_STATES(WS), .REFRESH_DIV(16'd49999)
  ) dut (
    .pCLK(pCLK), .pRESETn(pRESETn), .pADDR(pADDR), .pSELx(pSELx),
    .pENABLE(pENABLE), .pWRITE(pWRITE), .pWDATA(pWDATA), .pRDATA(pRDATA),
    .pREADY(pREADY), .pSLVERR(pSLVERR), .o_seg(o_seg), .o_dp(o_dp), .o_an(o_an)
  );

  initial pCLK = 1'b0;
  always #5 pCLK = ~pCLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Segment codes straight from the display table.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Behavioural model state
  logic [31:0]     m_data;
  logic [NDIG-1:0] m_dp;
  logic            m_en;
  int              m_presc;
  int              m_cnt;
  int              m_idx;
  logic [NDIG-1:0] e_an;
  logic [6:0]      e_seg;
  logic            e_dp;

  logic            commit_req = 1'b0;
  logic [4:0]      commit_ofs;
  logic [31:0]     commit_wd;
  logic            out_chk_on = 1'b0;

  function automatic logic [NDIG-1:0] an_for(input int d);
    logic [NDIG-1:0] a;
    for (int i = 0; i < NDIG; i++) a[i] = (i != d);
    return a;
  endfunction

  // Cycle-level model: display follows last cycle's state, then scan and write.
  always @(posedge pCLK or negedge pRESETn) begin
    if (!pRESETn) begin
      m_data <= '0; m_dp <= '0; m_en <= 1'b0; m_presc <= 49999;
      m_cnt <= 0; m_idx <= 0;
      e_an <= '1; e_seg <= 7'h7F; e_dp <= 1'b1;
    end else begin
      if (m_en) begin
        e_an  <= an_for(m_idx);
        e_seg <= seg_tab[(m_data >> (4 * m_idx)) % 16];
        e_dp  <= !m_dp[m_idx];
      end else begin
        e_an <= '1; e_seg <= 7'h7F; e_dp <= 1'b1;
      end
      if (!m_en) begin
        m_cnt <= 0; m_idx <= 0;
      end else if (m_cnt >= m_presc) begin
        m_cnt <= 0; m_idx <= (m_idx + 1) % NDIG;
      end else begin
        m_cnt <= m_cnt + 1;
      end
      if (commit_req) begin
        case (commit_ofs)
          5'h00: m_data  <= commit_wd;
          5'h04: m_dp    <= commit_wd[NDIG-1:0];
          5'h08: m_en    <= commit_wd[0];
          5'h0C: m_presc <= int'(commit_wd[15:0]);
          default: ;
        endcase
      end
    end
  end

  // Continuous display check away from the active edge.
  always @(negedge pCLK) begin
    if (pRESETn && out_chk_on) begin
      check("o_an",  32'(o_an),  32'(e_an));
      check("o_seg", 32'(o_seg), 32'(e_seg));
      check("o_dp",  32'(o_dp),  32'(e_dp));
    end
  end

  function automatic logic exp_err(input logic [31:0] a, input logic w);
    logic [4:0] o;
    o = a[4:0];
    if (o[1:0] != 2'b00) return 1'b1;
    if (o > 5'h10) return 1'b1;
    return (o == 5'h10) && w;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] o);
    case (o)
      5'h00: return m_data;
      5'h04: return 32'(m_dp);
      5'h08: return 32'(m_en);
      5'h0C: return 32'(m_presc);
      5'h10: return 32'(m_idx);
      default: return 32'h0;
    endcase
  endfunction

  // One APB transfer; starts and ends on a negedge, leaving the bus ready
  // for an immediate back-to-back SETUP.
  task automatic apb_xfer(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd);
    int waits;
    logic er;
    pSELx = 1'b1; pENABLE = 1'b0; pWRITE = w; pADDR = a; pWDATA = wd;
    @(negedge pCLK);
    pENABLE = 1'b1;
    #1;
    waits = 0;
    while (!pREADY && waits < 20) begin
      @(negedge pCLK); #1;
      waits++;
    end
    check("wait_states", 32'(waits), 32'(WS));
    er = exp_err(a, w);
    rd = pRDATA;
    check("pslverr", 32'(pSLVERR), 32'(er));
    if (er) check("rdata_err", pRDATA, 32'h0);
    else if (!w) check("rdata", pRDATA, exp_rd(a[4:0]));
    if (pREADY && w && !er) begin
      commit_ofs = a[4:0]; commit_wd = wd; commit_req = 1'b1;
    end
    @(negedge pCLK);
    commit_req = 1'b0;
    pSELx = 1'b0; pENABLE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge pCLK);
  endtask

  logic [31:0] rd;
  logic [31:0] tmp;
  int          waits;

  initial begin
    pRESETn = 1'b0; pSELx = 1'b0; pENABLE = 1'b0; pWRITE = 1'b0;
    pADDR = '0; pWDATA = '0;
    idle(3);
    pRESETn = 1'b1;
    out_chk_on = 1'b1;
    idle(1);

    // Reset state
    check("rst_an",  32'(o_an),  32'hFF);
    check("rst_seg", 32'(o_seg), 32'h7F);
    apb_xfer(1'b0, 32'h0C, 32'h0, rd);
    check("rst_presc", rd, 32'h0000C34F);
    apb_xfer(1'b0, 32'h00, 32'h0, rd);
    check("rst_data", rd, 32'h0);

    // DATA write with wait states, then readback
    apb_xfer(1'b1, 32'h00, 32'h89ABCDEF, rd);
    apb_xfer(1'b0, 32'h00, 32'h0, rd);
    check("data_rb", rd, 32'h89ABCDEF);

    // Fast scan: PRESC=0, digit0 point lit, enable
    apb_xfer(1'b1, 32'h0C, 32'h0, rd);
    apb_xfer(1'b1, 32'h04, 32'h01, rd);
    apb_xfer(1'b1, 32'h08, 32'h1, rd);
    idle(20);

    // Error accesses leave registers untouched
    apb_xfer(1'b0, 32'h14, 32'h0, rd);
    apb_xfer(1'b1, 32'h10, 32'h5, rd);
    apb_xfer(1'b0, 32'h02, 32'h0, rd);
    apb_xfer(1'b1, 32'h06, 32'hFFFF_FFFF, rd);
    apb_xfer(1'b0, 32'h00, 32'h0, rd);
    check("data_kept", rd, 32'h89ABCDEF);

    // Slower scan with STATUS sampling, then disable
    apb_xfer(1'b1, 32'h0C, 32'h3, rd);
    for (int i = 0; i < 6; i++) begin
      idle(i + 1);
      apb_xfer(1'b0, 32'h10, 32'h0, rd);
    end
    apb_xfer(1'b1, 32'h08, 32'h0, rd);
    idle(3);
    apb_xfer(1'b0, 32'h10, 32'h0, rd);
    check("idx_cleared", rd, 32'h0);

    // Reset asserted in the completing cycle of a write
    pSELx = 1'b1; pENABLE = 1'b0; pWRITE = 1'b1; pADDR = 32'h00; pWDATA = 32'h12345678;
    @(negedge pCLK);
    pENABLE = 1'b1;
    #1;
    waits = 0;
    while (!pREADY && waits < 20) begin
      @(negedge pCLK); #1;
      waits++;
    end
    check("rst_mid_ready_seen", 32'(pREADY), 32'h1);
    pRESETn = 1'b0;
    #1;
    check("rst_mid_pready", 32'(pREADY), 32'h0);
    check("rst_mid_an",  32'(o_an),  32'hFF);
    check("rst_mid_seg", 32'(o_seg), 32'h7F);
    check("rst_mid_dp",  32'(o_dp),  32'h1);
    @(negedge pCLK);
    pSELx = 1'b0; pENABLE = 1'b0;
    @(negedge pCLK);
    pRESETn = 1'b1;
    idle(1);
    apb_xfer(1'b0, 32'h00, 32'h0, rd);
    check("rst_mid_data", rd, 32'h0);
    apb_xfer(1'b0, 32'h0C, 32'h0, rd);
    check("rst_mid_presc", rd, 32'h0000C34F);

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      int op;
      op = $urandom_range(0, 9);
      case (op)
        0, 1: apb_xfer(1'b1, 32'h00, $urandom, rd);
        2:    apb_xfer(1'b1, 32'h04, $urandom, rd);
        3: begin
          tmp = $urandom & 32'hFFFF_FFFE;
          if ($urandom_range(0, 3) != 0) tmp = tmp | 32'h1;
          apb_xfer(1'b1, 32'h08, tmp, rd);
        end
        4: begin
          tmp = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 6));
          apb_xfer(1'b1, 32'h0C, tmp, rd);
        end
        5, 6, 7: apb_xfer(1'b0, 32'($urandom_range(0, 4) * 4), 32'h0, rd);
        8: begin
          tmp = $urandom;
          apb_xfer($urandom_range(0, 1) == 1, tmp, $urandom, rd);
        end
        default: apb_xfer(1'b1, 32'h10, $urandom, rd);
      endcase
      idle($urandom_range(0, 2));
    end

    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_sevenseg_slave.md
Name: apb_sevenseg_slave

Overview:
- APB completer that terminates the transfers issued by the team's APB master and owns a small register bank.
- The registers drive a multiplexed, active-low seven-segment display: hex digits, decimal points, enable and refresh prescaler.
- Sits on the peripheral side of the APB bus in the MCS seven-segment design. Configurable wait states exercise the master's pREADY handling.

Parameters:
- DW, 32, data width (fixed at 32 for register layout).
- AW, 32, address width.
- NDIG, 8, number of digits (1..8).
- WAIT_STATES, 0, pREADY-low cycles inserted in ACCESS for every transfer (0..7).
- REFRESH_DIV, 16'd49999, reset value of PRESC.

Ports:
- pCLK  in  1  clock
- pRESETn  in  1  reset, asynchronous, active-low
- pADDR  in  AW  byte address; only [4:0] decoded
- pSELx  in  1  select
- pENABLE  in  1  access phase
- pWRITE  in  1  1=write
- pWDATA  in  DW  write data
- pRDATA  out  DW  read data
- pREADY  out  1  transfer complete
- pSLVERR  out  1  error, valid with pREADY
- o_seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- o_dp  out  1  decimal point, active-low
- o_an  out  NDIG  digit anodes, active-low, one-hot-low when enabled

Behaviour:
- Reset (async assert, sync-safe deassert):
  - Registers: DATA=0, DP=0, CTRL=0, PRESC=REFRESH_DIV.
  - Internal: wait counter=0, prescaler count=0, digit idx=0.
  - Outputs: pREADY=0, pSLVERR=0, pRDATA=0, o_seg=7'h7F, o_dp=1, o_an=all ones.
- Register map (offset = pADDR[4:0]):
  - 0x00 DATA RW: nibble k = digit k; digit0 = [3:0].
  - 0x04 DP RW: [NDIG-1:0]; other bits read 0.
  - 0x08 CTRL RW: [0] EN; other bits read 0.
  - 0x0C PRESC RW: [15:0]; other bits read 0.
  - 0x10 STATUS RO: [2:0] current digit idx.
- Error conditions (checked in ACCESS): pADDR[1:0]!=0, unmapped offset, or write to STATUS → pSLVERR=1 in the completing cycle, no register change, pRDATA=0.
- APB FSM, states IDLE/ACCESS:
  - IDLE→ACCESS on pSELx & !pENABLE (SETUP); load wait counter=WAIT_STATES.
  - In ACCESS (pSELx & pENABLE): pREADY = (cnt==0); if cnt!=0, decrement.
  - ACCESS→IDLE on the pREADY cycle. A back-to-back SETUP on the following cycle is accepted.
  - pREADY, pSLVERR and pRDATA are 0 whenever not completing.
  - Write commit: register updates on the completing edge (pREADY & pWRITE & !err). A read in the same cycle returns the pre-write value.
  - pRDATA is combinational from registers during the completing cycle only.
  - pSELx dropping mid-ACCESS (protocol violation): return to IDLE, no commit.
- Scanner:
  - EN=0: prescaler count and idx held at 0; o_an=all ones, o_seg=7'h7F, o_dp=1.
  - EN=1: count increments each cycle. When count >= PRESC, count←0 and idx←(idx==NDIG-1)?0:idx+1.
  - PRESC=0 advances every cycle. Writing PRESC below the current count forces a wrap on the next cycle.
- Outputs registered, 1-cycle latency from idx/DATA/DP:
  - o_an[idx]=0, all others 1.
  - o_seg = hex decode of DATA nibble idx. Codes: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E (hex).
  - o_dp = ~DP[idx].
- Simultaneous events: a CTRL write clearing EN blanks outputs on the cycle after commit. A DATA write takes effect on the displayed digit one cycle after commit.

Test Plan:
- Reset then read 0x0C, WAIT_STATES=0 → completes in ACCESS cycle, pRDATA=0x0000C34F, pSLVERR=0; o_an=0xFF, o_seg=7F.
- WAIT_STATES=2: write DATA=0x89ABCDEF → pREADY low 2 ACCESS cycles, high on 3rd. Readback returns 0x89ABCDEF.
- Write PRESC=0, DP=0x01, CTRL=1 → o_an steps FE,FD,FB,…,7F,FE one per cycle. With digit0 active: o_seg=0E (F), o_dp=0. Digit7: o_seg=00.
- Read 0x14, write 0x10, read 0x02 → each pSLVERR=1, pRDATA=0, registers unchanged.
- PRESC=3, EN=1 → idx advances every 4 cycles. STATUS read returns the current idx. Clearing EN blanks outputs next cycle; idx returns to 0.
- Assert pRESETn low mid-ACCESS with WAIT_STATES=3 → immediate pREADY=0, registers return to reset values, outputs blank. The next transfer completes normally.
